// File: rtl/cmul_pkg.sv
// Shared types and constants for the complex-multiply issue scheduler.
// The tag struct travels alongside each product through the shared multiplier.
package cmul_pkg;

    localparam int DW = 12;
    localparam int PW = 24;
    localparam int RW = 25;

    localparam logic [1:0] P_RR = 2'd0;
    localparam logic [1:0] P_II = 2'd1;
    localparam logic [1:0] P_RI = 2'd2;
    localparam logic [1:0] P_IR = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] k;
        logic       neg;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, k: 2'd0, neg: 1'b0};

    // Two's-complement magnitude; the most negative value maps to 2^(DW-1) unsigned.
    function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] x);
        abs_mag = x[DW-1] ? (~x + {{(DW-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/cmul_tag_pipe.sv
// Delay line that keeps each issued product's tag aligned with the multiplier
// latency, so the returning mul_c can be attributed to the right partial product.
module cmul_tag_pipe
    import cmul_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t stage_r [LAT];

    // Shift register of tags, cleared so in-flight products are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage_r[i] <= TAG_NONE;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[LAT-1];

    // Any occupied stage means products are still in flight.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_valid = any_valid | stage_r[i].valid;
        end
    end

endmodule

// File: rtl/vedic_cmul_sched.sv
// Signed complex multiply built from four issues to one shared unsigned multiplier:
// magnitudes go out, signs ride the tag line, and products are recombined on return.
module vedic_cmul_sched #(
    parameter int MUL_LAT = 2,
    parameter int DW      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        ar,
    input  logic [DW-1:0]        ai,
    input  logic [DW-1:0]        br,
    input  logic [DW-1:0]        bi,
    output logic [DW-1:0]        mul_a,
    output logic [DW-1:0]        mul_b,
    input  logic [2*DW-1:0]      mul_c,
    output logic                 out_valid,
    output logic signed [2*DW:0] out_re,
    output logic signed [2*DW:0] out_im,
    output logic                 busy
);
    import cmul_pkg::*;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [1:0]            k_r;
    logic [1:0]            k_nxt_s;
    logic [DW-1:0]         ar_r, ai_r, br_r, bi_r;
    logic                  accept_s;
    logic [DW-1:0]         x_s, y_s;
    tag_t                  tag_in_s;
    tag_t                  tag_out_s;
    logic                  tag_any_s;
    logic signed [PW-1:0]  prod_s;
    logic signed [RW-1:0]  prod_ext_s;
    logic signed [RW-1:0]  acc_re_r, acc_im_r;

    // Accepting on the last issue slot restarts immediately, giving one op per 4 cycles.
    assign in_ready = !rst && ((state_r == IDLE) || ((state_r == ISSUE) && (k_r == P_IR)));
    assign accept_s = in_valid && in_ready;

    // Issue FSM next-state and product counter.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        if (accept_s) begin
            state_nxt_s = ISSUE;
            k_nxt_s     = P_RR;
        end else if (state_r == ISSUE) begin
            if (k_r == P_IR) begin
                state_nxt_s = IDLE;
                k_nxt_s     = P_RR;
            end else begin
                k_nxt_s     = k_r + 2'd1;
            end
        end else begin
            state_nxt_s = IDLE;
            k_nxt_s     = P_RR;
        end
    end

    // FSM state, counter and operand capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= 2'd0;
            ar_r    <= {DW{1'b0}};
            ai_r    <= {DW{1'b0}};
            br_r    <= {DW{1'b0}};
            bi_r    <= {DW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            if (accept_s) begin
                ar_r <= ar;
                ai_r <= ai;
                br_r <= br;
                bi_r <= bi;
            end
        end
    end

    // Operand pairing for the current partial product.
    always_comb begin
        x_s = {DW{1'b0}};
        y_s = {DW{1'b0}};
        case (k_r)
            P_RR:    begin x_s = ar_r; y_s = br_r; end
            P_II:    begin x_s = ai_r; y_s = bi_r; end
            P_RI:    begin x_s = ar_r; y_s = bi_r; end
            P_IR:    begin x_s = ai_r; y_s = br_r; end
            default: begin x_s = {DW{1'b0}}; y_s = {DW{1'b0}}; end
        endcase
    end

    assign mul_a    = (state_r == ISSUE) ? abs_mag(x_s) : {DW{1'b0}};
    assign mul_b    = (state_r == ISSUE) ? abs_mag(y_s) : {DW{1'b0}};
    assign tag_in_s = {(state_r == ISSUE), k_r, (x_s[DW-1] ^ y_s[DW-1])};

    cmul_tag_pipe #(
        .LAT(MUL_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in_s),
        .tag_out   (tag_out_s),
        .any_valid (tag_any_s)
    );

    // Magnitude product is at most 2^22, so negation stays inside 24 signed bits.
    assign prod_s     = tag_out_s.neg ? -$signed(mul_c) : $signed(mul_c);
    assign prod_ext_s = {prod_s[PW-1], prod_s};

    // Recombine returning products into the real and imaginary results.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re_r  <= {RW{1'b0}};
            acc_im_r  <= {RW{1'b0}};
            out_re    <= {RW{1'b0}};
            out_im    <= {RW{1'b0}};
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (tag_out_s.valid) begin
                case (tag_out_s.k)
                    P_RR: acc_re_r <= prod_ext_s;
                    P_II: acc_re_r <= acc_re_r - prod_ext_s;
                    P_RI: acc_im_r <= prod_ext_s;
                    P_IR: begin
                        out_re    <= acc_re_r;
                        out_im    <= acc_im_r + prod_ext_s;
                        out_valid <= 1'b1;
                    end
                    default: begin end
                endcase
            end
        end
    end

    assign busy = (state_r == ISSUE) || tag_any_s || out_valid;

endmodule
